// File: rtl/rs_pkg.sv
// Shared constants, FSM states and GF(2^8) helpers for the RS(255,239) decoder.
// Field is GF(2^8) with primitive polynomial 0x11D and alpha = 0x02.
package rs_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int RS_N     = 255;
  localparam int RS_K     = 239;
  localparam int RS_TWO_T = 16;
  localparam int RS_FCR   = 0;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } rs_state_e;

  // alpha^e as a constant; elaboration-time only
  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] v;
    int k;
    v = 8'h01;
    k = e % 255;
    for (int j = 0; j < 255; j++) begin
      if (j < k) begin
        v = {v[6:0], 1'b0} ^ (v[7] ? GF_POLY : 8'h00);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/gf_cmul.sv
// Constant GF(2^8) multiplier by alpha^P.
// Input bit b contributes column alpha^(P+b); the product is their XOR.
module gf_cmul
  import rs_pkg::*;
#(
  parameter int P = 0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] term [8];

  for (genvar b = 0; b < 8; b++) begin : g_col
    localparam logic [7:0] COL = gf_alpha_pow(P + b);
    assign term[b] = {8{a[b]}} & COL;
  end

  always_comb begin
    y = '0;
    for (int b = 0; b < 8; b++) begin
      y = y ^ term[b];
    end
  end

endmodule

// File: rtl/rs_syndrome.sv
// RS(255,239) syndrome stage: Horner accumulation of S_i = R(alpha^(FCR+i)).
// Results live in their own registers so the next codeword can start at once.
module rs_syndrome
  import rs_pkg::*;
#(
  parameter int N     = RS_N,
  parameter int TWO_T = RS_TWO_T,
  parameter int FCR   = RS_FCR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 synd_valid,
  output logic [8*TWO_T-1:0]   synd,
  output logic                 synd_zero,
  output logic                 len_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);

  rs_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [7:0]         acc_q [TWO_T];
  logic [7:0]         acc_d [TWO_T];
  logic [7:0]         mul   [TWO_T];
  logic [8*TWO_T-1:0] synd_q, synd_d;
  logic               synd_valid_q, synd_valid_d;
  logic               synd_zero_q, synd_zero_d;
  logic               len_err_q, len_err_d;
  logic               cw_close;

  for (genvar i = 0; i < TWO_T; i++) begin : g_lane
    gf_cmul #(.P(FCR + i)) u_cmul (
      .a (acc_q[i]),
      .y (mul[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    synd_d       = synd_q;
    synd_valid_d = 1'b0;
    synd_zero_d  = synd_zero_q;
    len_err_d    = len_err_q;
    cnt_inc      = cnt_q + 1'b1;
    cw_close     = 1'b0;
    if (in_valid) begin
      cw_close = in_last || (cnt_inc == CNT_N);
      for (int i = 0; i < TWO_T; i++) begin
        unique case (state_q)
          ST_IDLE: acc_d[i] = in_data;
          ST_RUN:  acc_d[i] = mul[i] ^ in_data;
          default: acc_d[i] = in_data;
        endcase
      end
      if (cw_close) begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        synd_valid_d = 1'b1;
        for (int i = 0; i < TWO_T; i++) begin
          synd_d[8*i +: 8] = acc_d[i];
        end
        synd_zero_d = ~|synd_d;
        len_err_d   = ~(in_last && (cnt_inc == CNT_N));
      end else begin
        state_d = ST_RUN;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      synd_q       <= '0;
      synd_valid_q <= 1'b0;
      synd_zero_q  <= 1'b0;
      len_err_q    <= 1'b0;
      for (int i = 0; i < TWO_T; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      synd_q       <= synd_d;
      synd_valid_q <= synd_valid_d;
      synd_zero_q  <= synd_zero_d;
      len_err_q    <= len_err_d;
      for (int i = 0; i < TWO_T; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign synd_valid = synd_valid_q;
  assign synd       = synd_q;
  assign synd_zero  = synd_zero_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_rs_syndrome.sv
// Bench for rs_syndrome: directed and random codewords against a
// polynomial-evaluation syndrome model and a systematic RS encoder model.
module tb_rs_syndrome;

  localparam int N   = 255;
  localparam int TT  = 16;
  localparam int FCR = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         synd_valid;
  logic [127:0] synd;
  logic         synd_zero;
  logic         len_err;

  always #5 clk = ~clk;

  rs_syndrome dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .synd_valid (synd_valid),
    .synd       (synd),
    .synd_zero  (synd_zero),
    .len_err    (len_err)
  );

  int           tests = 0;
  int           fails = 0;
  int           spurious = 0;
  int           pulses = 0;
  int           p0;
  bit           pending = 0;
  logic [127:0] exp_synd;
  logic [127:0] last_synd;
  logic         exp_zero;
  logic         exp_lerr;
  logic [7:0]   exp_tab [255];
  logic [7:0]   g [17];
  logic [7:0]   cur [$];
  logic [7:0]   sd [$];
  bit           sl [$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // S_i = sum_j r_j * alpha^((FCR+i)*deg_j), deg_j = L-1-j
  function automatic logic [127:0] ref_synd(input logic [7:0] b [$]);
    logic [127:0] s;
    logic [7:0]   acc;
    int           L;
    s = '0;
    L = b.size();
    for (int i = 0; i < TT; i++) begin
      acc = 8'h00;
      for (int j = 0; j < L; j++) begin
        acc = acc ^ gf_mul(b[j], exp_tab[((FCR + i) * (L - 1 - j)) % 255]);
      end
      s[8*i +: 8] = acc;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (pending) begin
      chk("pulse", {127'd0, synd_valid}, 128'd1);
      chk("synd", synd, exp_synd);
      chk("synd_zero", {127'd0, synd_zero}, {127'd0, exp_zero});
      chk("len_err", {127'd0, len_err}, {127'd0, exp_lerr});
      last_synd = synd;
      pulses++;
      pending = 0;
    end else if (synd_valid !== 1'b0) begin
      spurious++;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit l);
    sd.push_back(b);
    sl.push_back(l);
  endtask

  task automatic send(input int gap);
    for (int j = 0; j < sd.size(); j++) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = sd[j];
      in_last  = sl[j];
      cur.push_back(sd[j]);
      if (sl[j] || cur.size() == N) begin
        exp_synd = ref_synd(cur);
        exp_zero = (exp_synd == '0);
        exp_lerr = !(sl[j] && cur.size() == N);
        pending  = 1;
        cur.delete();
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sd.delete();
    sl.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // mode 0: message 1..239; otherwise random message
  task automatic enc(input int mode);
    logic [7:0] rem [16];
    logic [7:0] m, fb;
    for (int k = 0; k < 16; k++) rem[k] = 8'h00;
    for (int j = 0; j < N - TT; j++) begin
      m = (mode == 0) ? 8'(j + 1) : 8'($urandom);
      push(m, 1'b0);
      fb = m ^ rem[15];
      for (int k = 15; k > 0; k--) rem[k] = rem[k-1] ^ gf_mul(fb, g[k]);
      rem[0] = gf_mul(fb, g[0]);
    end
    for (int k = 15; k >= 0; k--) push(rem[k], k == 0);
  endtask

  task automatic rand_cw();
    for (int j = 0; j < N; j++) push(8'($urandom), j == N - 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cur.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    exp_tab[0] = 8'h01;
    for (int k = 1; k < 255; k++) exp_tab[k] = gf_mul(exp_tab[k-1], 8'h02);
    for (int k = 0; k < 17; k++) g[k] = (k == 0) ? 8'h01 : 8'h00;
    for (int i = 0; i < TT; i++) begin
      for (int k = i + 1; k > 0; k--) g[k] = g[k-1] ^ gf_mul(g[k], exp_tab[FCR + i]);
      g[0] = gf_mul(g[0], exp_tab[FCR + i]);
    end

    do_reset();
    chk("rst_valid", {127'd0, synd_valid}, 128'd0);
    chk("rst_synd", synd, 128'd0);
    chk("rst_zero", {127'd0, synd_zero}, 128'd0);
    chk("rst_lerr", {127'd0, len_err}, 128'd0);

    for (int j = 0; j < N; j++) push(8'h00, j == N - 1);
    send(0);
    idle(3);

    enc(0);
    send(0);
    idle(3);
    chk("enc_synd0", last_synd, 128'd0);

    for (int j = 0; j < N; j++) push((j == N - 1) ? 8'h5A : 8'h00, j == N - 1);
    send(0);
    idle(3);
    chk("deg0_5a", last_synd, {16{8'h5A}});

    for (int j = 0; j < N; j++) push((j == 0) ? 8'h01 : 8'h00, j == N - 1);
    send(0);
    idle(3);
    chk("deg254_s0", {120'd0, last_synd[7:0]}, 128'h01);
    chk("deg254_s1", {120'd0, last_synd[15:8]}, 128'h8E);

    p0 = pulses;
    rand_cw();
    rand_cw();
    send(0);
    idle(3);
    rand_cw();
    enc(1);
    send(30);
    idle(3);
    chk("b2b_pulses", 128'(pulses - p0), 128'd4);

    p0 = pulses;
    for (int j = 0; j < 100; j++) push(8'($urandom), j == 99);
    send(0);
    push(8'hC3, 1'b1);
    for (int j = 0; j < N; j++) push(8'($urandom), 1'b0);
    send(0);
    idle(3);
    chk("lerr_pulses", 128'(pulses - p0), 128'd3);

    p0 = pulses;
    for (int j = 0; j < 50; j++) push(8'($urandom), 1'b0);
    send(0);
    do_reset();
    idle(3);
    chk("rst_mid_pulses", 128'(pulses - p0), 128'd0);
    chk("rst_mid_synd", synd, 128'd0);
    enc(1);
    send(10);
    idle(3);
    chk("after_rst_synd", last_synd, 128'd0);
    chk("after_rst_pulses", 128'(pulses - p0), 128'd1);

    chk("spurious", 128'(spurious), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
